// File: rtl/async_sub_pkg.sv
// -----------------------------------------------------------------------------
// async_sub_pkg
// Shared types and constants for the async_sub push-button decimal
// down-counter: the digit type, its upper bound, the common-cathode
// seven-segment patterns ({g,f,e,d,c,b,a}, active-high) and the
// wrap-around decrement used by the counter.
// -----------------------------------------------------------------------------
package async_sub_pkg;

    typedef logic [3:0] digit_t;

    localparam digit_t DIGIT_MAX = 4'd9;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // 0 wraps to 9; an out-of-range value (10..15) is pulled back to 9 too.
    function automatic digit_t next_digit(input digit_t d);
        return (d == 4'd0 || d > DIGIT_MAX) ? DIGIT_MAX : d - 4'd1;
    endfunction

endpackage

// File: rtl/async_sub_if.sv
// -----------------------------------------------------------------------------
// async_sub_if
// Board-side pin bundle of async_sub: the raw push-button and the
// seven-segment drive.
//   button : raw asynchronous push-button, active-high
//   leds   : segment drive {g,f,e,d,c,b,a}, active-high
// Modports:
//   master : the board / stimulus side (drives button, observes leds)
//   slave  : the counter side (samples button, drives leds)
// -----------------------------------------------------------------------------
interface async_sub_if;

    logic       button;
    logic [6:0] leds;

    modport master (output button, input leds);
    modport slave  (input button, output leds);

endinterface

// File: rtl/async_sub_seg7_decoder.sv
// -----------------------------------------------------------------------------
// seg7_decoder
// Purely combinational decimal digit to common-cathode seven-segment decode.
// Ports:
//   digit    : in,  4-bit value; 0..9 shown, 10..15 shown blank
//   segments : out, {g,f,e,d,c,b,a}, active-high
// -----------------------------------------------------------------------------
module seg7_decoder
    import async_sub_pkg::*;
(
    input  digit_t      digit,
    output logic [6:0]  segments
);

    always_comb begin
        // NOTE: the default assignment ahead of the case keeps every path
        // driven, so no latch is inferred for the unlisted codes.
        segments = SEG_BLANK;
        unique case (digit)
            4'd0:    segments = SEG_0;
            4'd1:    segments = SEG_1;
            4'd2:    segments = SEG_2;
            4'd3:    segments = SEG_3;
            4'd4:    segments = SEG_4;
            4'd5:    segments = SEG_5;
            4'd6:    segments = SEG_6;
            4'd7:    segments = SEG_7;
            4'd8:    segments = SEG_8;
            4'd9:    segments = SEG_9;
            default: segments = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/async_sub.sv
// -----------------------------------------------------------------------------
// async_sub
// Single-digit decimal down-counter driven by a push-button. The raw button
// is brought into the clk domain by a two-flop synchronizer, optionally
// debounced, and rising-edge detected; each detected press decrements the
// digit (0 wraps to 9). The digit is decoded combinationally onto a
// common-cathode seven-segment display.
//
// Optional feature: define ASYNC_SUB_DEBOUNCE_EN to insert an 8-bit
// stability counter between the synchronizer and the edge detect.
//
// Parameters:
//   DEBOUNCE_CYCLES : clocks the synchronized level must differ from the
//                     accepted level before it is taken (1..255, debounce only)
// Ports (positional order leds, reset, button, clk):
//   leds   : out, segment drive {g,f,e,d,c,b,a}, active-high
//   reset  : in,  asynchronous active-low reset
//   button : in,  raw asynchronous push-button, active-high
//   clk    : in,  system clock, rising edge
// -----------------------------------------------------------------------------
module async_sub
    import async_sub_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 2
) (
    output logic [6:0] leds,
    input  logic       reset,
    input  logic       button,
    input  logic       clk
);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_cfg
        $error("async_sub: DEBOUNCE_CYCLES must lie in 1..255");
    end

    logic   sync1;
    logic   sync2;
    logic   level;      // level fed to the edge detect
    logic   level_q;    // one-cycle-delayed copy of level
    logic   press;
    digit_t digit;

    // Two-flop synchronizer. Clearing to 0 means a button held through reset
    // release still shows a clean 0->1 transition and counts once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let sync2 take the old sync1,
            // forming a real two-stage chain rather than one flop.
            sync1 <= button;
            sync2 <= sync1;
        end
    end

`ifdef ASYNC_SUB_DEBOUNCE_EN
    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [7:0] stable_cnt;
    logic       db_level;

    // The accepted level flips only after sync2 has disagreed with it on
    // DEBOUNCE_CYCLES consecutive clocks; any agreement restarts the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable_cnt <= 8'd0;
            db_level   <= 1'b0;
        end else if (sync2 != db_level) begin
            if (stable_cnt == DB_LAST) begin
                stable_cnt <= 8'd0;
                db_level   <= sync2;
            end else begin
                stable_cnt <= stable_cnt + 8'd1;
            end
        end else begin
            stable_cnt <= 8'd0;
        end
    end

    assign level = db_level;
`else
    assign level = sync2;
`endif

    assign press = level & ~level_q;

    // Edge-detect delay and the digit counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_q <= 1'b0;
            digit   <= 4'd0;
        end else begin
            level_q <= level;
            if (press) begin
                digit <= next_digit(digit);
            end
        end
    end

    seg7_decoder u_decoder (
        .digit    (digit),
        .segments (leds)
    );

endmodule

// File: tb/tb_async_sub.sv
// -----------------------------------------------------------------------------
// tb_async_sub
// Directed self-checking bench for async_sub. Expected digits and segment
// patterns are hand-written constants. Define ASYNC_SUB_DEBOUNCE_EN for the
// debounced build (DUT then runs with DEBOUNCE_CYCLES = 4).
// -----------------------------------------------------------------------------
module tb_async_sub;

`ifdef ASYNC_SUB_DEBOUNCE_EN
    localparam int DC    = 4;
    localparam int LAT   = 2 + DC;     // edge index of the update after edge k
    localparam int PHASE = 2 + DC + 2; // high/low phase length of a press
`else
    localparam int DC    = 2;
    localparam int LAT   = 2;
    localparam int PHASE = 5;
`endif

    logic clk;
    logic reset;

    int errors = 0;
    int checks = 0;

    logic [6:0] seg_exp [10];

    async_sub_if pins ();

    async_sub #(.DEBOUNCE_CYCLES(DC)) dut (
        .leds   (pins.leds),
        .reset  (reset),
        .button (pins.button),
        .clk    (clk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_state(input string name, input logic [3:0] d_exp,
                               input logic [6:0] l_exp);
        checks++;
        if (dut.digit !== d_exp) begin
            errors++;
            $display("FAIL %s: digit=%0d expected %0d", name, dut.digit, d_exp);
        end
        checks++;
        if (pins.leds !== l_exp) begin
            errors++;
            $display("FAIL %s: leds=%b expected %b", name, pins.leds, l_exp);
        end
    endtask

    task automatic press_once();
        pins.button = 1'b1;
        tick(PHASE);
        pins.button = 1'b0;
        tick(PHASE);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(2);
    endtask

    task automatic test_reset();
        pins.button = 1'b0;
        reset = 1'b0;
        tick(3);
        check_state("reset_asserted", 4'd0, 7'b0111111);
        reset = 1'b1;
        tick(10);
        check_state("reset_idle_10", 4'd0, 7'b0111111);
        tick(10);
        check_state("reset_idle_20", 4'd0, 7'b0111111);
    endtask

    task automatic test_single_press();
        pins.button = 1'b1;         // next rising edge is edge k
        tick(LAT);                  // now just after edge k+LAT-1
        check_state("press_before_latency", 4'd0, 7'b0111111);
        tick(1);                    // just after edge k+LAT
        check_state("press_at_latency", 4'd9, 7'b1101111);
        tick(PHASE - LAT - 1);
        pins.button = 1'b0;
        tick(PHASE);
        check_state("press_release", 4'd9, 7'b1101111);
    endtask

    task automatic test_ten_presses();
        logic [3:0] exp_d;
        pulse_reset();
        exp_d = 4'd0;
        for (int i = 0; i < 10; i++) begin
            press_once();
            exp_d = (exp_d == 4'd0) ? 4'd9 : exp_d - 4'd1;
            check_state($sformatf("ten_presses_%0d", i), exp_d, seg_exp[exp_d]);
        end
        check_state("ten_presses_final", 4'd0, 7'b0111111);
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        repeat (4) press_once();    // 0 -> 9 -> 8 -> 7 -> 6
        check_state("mid_before_reset", 4'd6, 7'b1111101);
        #2 reset = 1'b0;            // between clock edges
        #1;
        check_state("mid_async_reset", 4'd0, 7'b0111111);
        tick(2);
        reset = 1'b1;
        tick(2);
        press_once();
        check_state("mid_after_1", 4'd9, 7'b1101111);
        press_once();
        check_state("mid_after_2", 4'd8, 7'b1111111);
        press_once();
        check_state("mid_after_3", 4'd7, 7'b0000111);
    endtask

    task automatic test_held_through_reset();
        reset = 1'b0;
        pins.button = 1'b1;
        tick(3);
        check_state("held_in_reset", 4'd0, 7'b0111111);
        reset = 1'b1;
        tick(LAT + 3);
        check_state("held_one_press", 4'd9, 7'b1101111);
        tick(20);
        check_state("held_no_more", 4'd9, 7'b1101111);
        pins.button = 1'b0;
        tick(PHASE);
        check_state("held_released", 4'd9, 7'b1101111);
    endtask

`ifdef ASYNC_SUB_DEBOUNCE_EN
    task automatic test_debounce();
        pulse_reset();
        pins.button = 1'b1;
        tick(2);
        pins.button = 1'b0;
        tick(12);
        check_state("glitch_ignored", 4'd0, 7'b0111111);
        pins.button = 1'b1;         // next rising edge is edge k
        tick(6);                    // just after edge k+5
        check_state("debounce_k5", 4'd0, 7'b0111111);
        tick(1);                    // just after edge k+6
        check_state("debounce_k6", 4'd9, 7'b1101111);
        tick(1);
        pins.button = 1'b0;
        tick(12);
        check_state("debounce_release", 4'd9, 7'b1101111);
    endtask
`endif

    initial begin
        seg_exp[0] = 7'b0111111; seg_exp[1] = 7'b0000110;
        seg_exp[2] = 7'b1011011; seg_exp[3] = 7'b1001111;
        seg_exp[4] = 7'b1100110; seg_exp[5] = 7'b1101101;
        seg_exp[6] = 7'b1111101; seg_exp[7] = 7'b0000111;
        seg_exp[8] = 7'b1111111; seg_exp[9] = 7'b1101111;
        reset = 1'b0;
        pins.button = 1'b0;
        #1;

        test_reset();
        test_single_press();
        test_ten_presses();
        test_reset_mid();
        test_held_through_reset();
`ifdef ASYNC_SUB_DEBOUNCE_EN
        test_debounce();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
